// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scanout reads > clear engine > sample writer.
// All RAM controls are registered; read data returns two cycles after the request.
module fb_port_arbiter #(
  parameter int                ADDR_W    = 15,
  parameter int                DATA_W    = 9,
  parameter int                FB_DEPTH  = 19200,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_rd,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              stall_clr,
  output logic [15:0]       stall_cnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One extra bit so FB_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  logic              grant_rd, grant_clr, grant_wr;
  logic              rd_in_range, wr_in_range;
  logic              rd_p1, oor_p1, oor_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    rd_in_range  = ({1'b0, disp_addr} < DEPTH_EXT);
    wr_in_range  = ({1'b0, wr_addr} < DEPTH_EXT);
    grant_rd     = disp_rd;
    grant_clr    = !disp_rd && (state == CLEAR);
    grant_wr     = !disp_rd && (state == IDLE) && wr_req;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end
      end
      CLEAR: begin
        // A scanout read stalls the sweep; the address only moves on a granted write.
        if (grant_clr) begin
          clr_addr_nxt = clr_addr + ADDR_W'(1);
          if (clr_addr == LAST_ADDR) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_ack   = grant_wr;
  assign clr_busy = (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (grant_rd) begin
        mem_en   <= rd_in_range;
        mem_addr <= disp_addr;
      end else if (grant_clr) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= clr_addr;
        mem_wdata <= CLR_VALUE;
      end else if (grant_wr) begin
        mem_en    <= wr_in_range;
        mem_we    <= wr_in_range;
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
    end
  end

  // Out-of-range reads skip the RAM but still produce a background pixel on time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_p1       <= 1'b0;
      oor_p1      <= 1'b0;
      disp_rvalid <= 1'b0;
      oor_p2      <= 1'b0;
    end else begin
      rd_p1       <= disp_rd;
      oor_p1      <= disp_rd && !rd_in_range;
      disp_rvalid <= rd_p1;
      oor_p2      <= oor_p1;
    end
  end

  assign disp_rdata = disp_rvalid ? (oor_p2 ? CLR_VALUE : mem_rdata) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (wr_req && !wr_ack && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a small synchronous RAM model and
// FB_DEPTH=16 so clears complete quickly.
module tb_fb_port_arbiter;

  localparam int             ADDR_W = 15;
  localparam int             DATA_W = 9;
  localparam int             DEPTH  = 16;
  localparam logic [8:0]     CLR    = 9'h0A5;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_rd;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              clr_start;
  logic              clr_busy;
  logic              stall_clr;
  logic [15:0]       stall_cnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [8:0] ram [DEPTH];
  int         clr_cnt [DEPTH];
  int         oob_cnt = 0;
  logic       pl_go = 1'b0;
  logic [8:0] pl_base = '0;

  int checks = 0;
  int errors = 0;
  int n_ok;

  fb_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_DEPTH(DEPTH), .CLR_VALUE(CLR)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_rd(disp_rd), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .stall_clr(stall_clr), .stall_cnt(stall_cnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model; preload also zeroes the per-address clear-write counters.
  always @(posedge clk) begin
    if (pl_go) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram[i]     <= pl_base + 9'(i);
        clr_cnt[i] <= 0;
      end
    end else if (mem_en) begin
      if (mem_addr < ADDR_W'(DEPTH)) begin
        if (mem_we) begin
          ram[mem_addr[3:0]] <= mem_wdata;
          if (mem_wdata == CLR) clr_cnt[mem_addr[3:0]] <= clr_cnt[mem_addr[3:0]] + 1;
        end else begin
          mem_rdata <= ram[mem_addr[3:0]];
        end
      end else begin
        oob_cnt <= oob_cnt + 1;
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic [ADDR_W-1:0] raddr,
                               input logic wreq, input logic [ADDR_W-1:0] waddr,
                               input logic [DATA_W-1:0] wdat,
                               input logic cstart, input logic sclr);
    disp_rd   = rd;
    disp_addr = raddr;
    wr_req    = wreq;
    wr_addr   = waddr;
    wr_data   = wdat;
    clr_start = cstart;
    stall_clr = sclr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [8:0] base);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    pl_base = base;
    pl_go   = 1'b1;
    nextCycle();
    pl_go   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    #10;
    checkOutput("reset_mem_en", 32'(mem_en), 0);
    checkOutput("reset_rvalid", 32'(disp_rvalid), 0);
    checkOutput("reset_clr_busy", 32'(clr_busy), 0);
    checkOutput("reset_stall_cnt", 32'(stall_cnt), 0);
    checkOutput("reset_wr_ack", 32'(wr_ack), 0);
    nextCycle();
    rst = 1'b0;

    $display("[TB] read stream");
    preload(9'd10);
    for (int i = 0; i < 7; i++) begin
      nextCycle();
      applyStimulus(i < 4, ADDR_W'(i), 1'b0, '0, '0, 1'b0, 1'b0);
      if (i == 1) checkOutput("rd_issue_addr", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 15'd0}));
      if (i >= 2 && i <= 5) begin
        checkOutput("rd_rvalid", 32'(disp_rvalid), 1);
        checkOutput("rd_data", 32'(disp_rdata), 32'(10 + i - 2));
      end
      if (i == 6) checkOutput("rd_rvalid_end", 32'(disp_rvalid), 0);
    end

    $display("[TB] contention");
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      applyStimulus(i < 3, '0, i <= 3, 15'd5, 9'h1A5, 1'b0, 1'b0);
      if (i < 3) checkOutput("cont_no_ack", 32'(wr_ack), 0);
      if (i == 3) begin
        checkOutput("cont_ack", 32'(wr_ack), 1);
        checkOutput("cont_stall3", 32'(stall_cnt), 3);
      end
      if (i == 4) checkOutput("cont_wr_issue", 32'({mem_en, mem_we, mem_addr, mem_wdata}),
                              32'({1'b1, 1'b1, 15'd5, 9'h1A5}));
      if (i == 5) checkOutput("cont_ram5", 32'(ram[5]), 32'h1A5);
    end

    $display("[TB] clear, writer blocked");
    preload(9'h1F0);
    n_ok = 0;
    for (int i = 0; i < 19; i++) begin
      nextCycle();
      applyStimulus(1'b0, '0, (i >= 1 && i <= 17), 15'd3, 9'h077, i == 0, i == 0);
      if (i >= 1 && i <= 16 && wr_ack) n_ok++;
      if (i == 1) checkOutput("clr_busy_first", 32'(clr_busy), 1);
      if (i == 16) checkOutput("clr_busy_last", 32'(clr_busy), 1);
      if (i == 17) begin
        checkOutput("clr_busy_done", 32'(clr_busy), 0);
        checkOutput("clr_wr_ack_after", 32'(wr_ack), 1);
        checkOutput("clr_stall16", 32'(stall_cnt), 16);
      end
      if (i == 18) checkOutput("clr_wr_issue", 32'({mem_we, mem_addr}), 32'({1'b1, 15'd3}));
    end
    checkOutput("clr_acks_during", 32'(n_ok), 0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    n_ok = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] == CLR) n_ok++;
    checkOutput("clr_ram_cleared", 32'(n_ok), 15);
    checkOutput("clr_ram3_writer", 32'(ram[3]), 32'h077);
    n_ok = 0;
    for (int i = 0; i < DEPTH; i++) if (clr_cnt[i] == 1) n_ok++;
    checkOutput("clr_once_each", 32'(n_ok), 16);

    $display("[TB] clear interleaved with reads");
    preload(9'h100);
    for (int i = 0; i < 35; i++) begin
      nextCycle();
      applyStimulus((i % 2 == 1) && (i <= 31), '0, 1'b0, '0, '0, i == 0, 1'b0);
      if (i == 3) checkOutput("ilv_pre_clear", 32'({disp_rvalid, disp_rdata}), 32'({1'b1, 9'h100}));
      if (i == 5) checkOutput("ilv_post_clear", 32'({disp_rvalid, disp_rdata}), 32'({1'b1, CLR}));
      if (i == 32) checkOutput("ilv_busy_last", 32'(clr_busy), 1);
      if (i == 33) checkOutput("ilv_busy_done", 32'(clr_busy), 0);
    end
    n_ok = 0;
    for (int i = 0; i < DEPTH; i++) if (clr_cnt[i] == 1 && ram[i] == CLR) n_ok++;
    checkOutput("ilv_once_each", 32'(n_ok), 16);

    $display("[TB] out of range");
    preload(9'h1C0);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      applyStimulus(i < 2, (i == 1) ? 15'd16 : 15'd1, i == 3, 15'd16, 9'h055, 1'b0, 1'b0);
      if (i == 2) begin
        checkOutput("oor_prev_read", 32'({disp_rvalid, disp_rdata}), 32'({1'b1, 9'h1C1}));
        checkOutput("oor_rd_no_mem", 32'(mem_en), 0);
      end
      if (i == 3) begin
        checkOutput("oor_rd_data", 32'({disp_rvalid, disp_rdata}), 32'({1'b1, CLR}));
        checkOutput("oor_wr_ack", 32'(wr_ack), 1);
      end
      if (i == 4) checkOutput("oor_wr_no_mem", 32'({mem_en, disp_rvalid}), 0);
    end

    $display("[TB] reset mid-clear");
    preload(9'h1E0);
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      applyStimulus(i == 8, '0, 1'b0, '0, '0, i == 0, 1'b0);
    end
    checkOutput("rst_pre_busy_en", 32'({clr_busy, mem_en}), 32'b11);
    rst = 1'b1;
    #1;
    checkOutput("rst_outputs", 32'({clr_busy, mem_en, mem_we, disp_rvalid}), 0);
    checkOutput("rst_stall", 32'(stall_cnt), 0);
    n_ok = 0;
    for (int i = 0; i < DEPTH; i++) if (clr_cnt[i] == 1) n_ok++;
    checkOutput("rst_cleared_upto7", 32'({n_ok[7:0], 7'(clr_cnt[7])}), 32'({8'd7, 7'd0}));
    nextCycle();
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(1'b0, '0, i == 0, 15'd4, 9'h0F0, 1'b0, 1'b0);
      if (i == 0) checkOutput("rst_idle_ack", 32'({wr_ack, clr_busy}), 32'b10);
      checkOutput("rst_no_rvalid", 32'(disp_rvalid), 0);
    end

    $display("[TB] stall saturation");
    for (int n = 0; n < 70000; n++) begin
      nextCycle();
      applyStimulus(1'b1, '0, 1'b1, 15'd2, 9'h011, 1'b0, 1'b0);
      if (n == 65534) checkOutput("sat_fffe", 32'(stall_cnt), 32'hFFFE);
      if (n == 65535) checkOutput("sat_ffff", 32'(stall_cnt), 32'hFFFF);
    end
    nextCycle();
    applyStimulus(1'b1, '0, 1'b1, 15'd2, 9'h011, 1'b0, 1'b1);
    checkOutput("sat_hold", 32'(stall_cnt), 32'hFFFF);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("sat_clr_wins", 32'(stall_cnt), 0);
    checkOutput("never_oob_access", 32'(oob_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
